// File: rtl/crc_pkg.sv
// Shared widths, default generator polynomial and a single-bit LFSR step for the serial CRC.
package crc_pkg;

    localparam int DATA_W = 3;
    localparam int CRC_W  = 4;
    localparam logic [CRC_W-1:0] CRC4_POLY = 4'b0011;

    // Next LFSR state after shifting in one message bit, MSB-first.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] lfsr,
                                                  input logic              din);
        logic fb;
        fb = din ^ lfsr[CRC_W-1];
        return {lfsr[CRC_W-2:0], 1'b0} ^ (fb ? CRC4_POLY : '0);
    endfunction

endpackage

// File: rtl/crc_lfsr_step.sv
// Combinational single-bit CRC LFSR update (Galois form, implicit x^CRC_W term).
// Latency: zero cycles, purely combinational.
// Backpressure: none; the output follows the inputs.
module crc_lfsr_step #(
    parameter int               CRC_W = crc_pkg::CRC_W,
    parameter logic [CRC_W-1:0] POLY  = crc_pkg::CRC4_POLY
) (
    input  logic [CRC_W-1:0] lfsr_i,
    input  logic             bit_i,
    output logic [CRC_W-1:0] lfsr_o
);
    logic fb;

    always_comb begin
        fb     = bit_i ^ lfsr_i[CRC_W-1];
        lfsr_o = {lfsr_i[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end

endmodule

// File: rtl/crc_one.sv
// Free-running serial CRC encoder: capture one word, shift it MSB-first through the LFSR.
// Latency: code and done pulse register 3 edges after the capture edge; frame period DATA_W+1.
// Backpressure: none; the consumer must sample o_crc_code while o_crc_done is high.
module crc_one #(
    parameter int                    DATA_W = crc_pkg::DATA_W,
    parameter int                    CRC_W  = crc_pkg::CRC_W,
    parameter logic [CRC_W-1:0]      POLY   = crc_pkg::CRC4_POLY
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_data,
    output logic [CRC_W-1:0]  o_crc_code,
    output logic              o_crc_done
);
    import crc_pkg::*;

    localparam int               CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W);

    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] shreg_q;
    logic [CRC_W-1:0]  lfsr_q;
    logic [CRC_W-1:0]  lfsr_d;
    logic [CRC_W-1:0]  crc_q;
    logic              done_q;

    crc_lfsr_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_step (
        .lfsr_i (lfsr_q),
        .bit_i  (shreg_q[DATA_W-1]),
        .lfsr_o (lfsr_d)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q   <= '0;
            shreg_q <= '0;
            lfsr_q  <= '0;
            crc_q   <= '0;
            done_q  <= 1'b0;
        end else if (cnt_q == '0) begin
            shreg_q <= i_data;
            lfsr_q  <= '0;
            done_q  <= 1'b0;
            cnt_q   <= CNT_W'(1);
        end else begin
            lfsr_q  <= lfsr_d;
            shreg_q <= shreg_q << 1;
            // Publish the remainder including the final bit; crc_q holds until the next frame ends.
            if (cnt_q == LAST) begin
                crc_q  <= lfsr_d;
                done_q <= 1'b1;
                cnt_q  <= '0;
            end else begin
                done_q <= 1'b0;
                cnt_q  <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign o_crc_code = crc_q;
    assign o_crc_done = done_q;

endmodule

// File: tb/tb_crc_one.sv
// Directed, table-driven bench for crc_one with hand-computed CRC-4 (x^4+x+1) remainders.
module tb_crc_one;

    logic       clk;
    logic       rst_n;
    logic [2:0] i_data;
    logic [3:0] o_crc_code;
    logic       o_crc_done;

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] prev_code;

    typedef struct {
        logic [2:0] data;
        logic [3:0] code;
    } vec_t;

    vec_t tbl [8];

    crc_one dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_data     (i_data),
        .o_crc_code (o_crc_code),
        .o_crc_done (o_crc_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One full frame; cap is present at the capture edge, mid afterwards.
    task automatic run_frame(input logic [2:0] cap, input logic [2:0] mid,
                             input logic [3:0] exp, input string nm);
        i_data = cap;
        tick();
        chk({nm, " capture done"}, 32'(o_crc_done), 32'd0);
        chk({nm, " capture hold"}, 32'(o_crc_code), 32'(prev_code));
        i_data = mid;
        for (int k = 1; k < 3; k++) begin
            tick();
            chk({nm, " shift done"}, 32'(o_crc_done), 32'd0);
            chk({nm, " shift hold"}, 32'(o_crc_code), 32'(prev_code));
        end
        tick();
        chk({nm, " done pulse"}, 32'(o_crc_done), 32'd1);
        chk({nm, " code"}, 32'(o_crc_code), 32'(exp));
        prev_code = exp;
    endtask

    initial begin
        tbl[0] = '{3'd0, 4'b0000};
        tbl[1] = '{3'd1, 4'b0011};
        tbl[2] = '{3'd2, 4'b0110};
        tbl[3] = '{3'd3, 4'b0101};
        tbl[4] = '{3'd4, 4'b1100};
        tbl[5] = '{3'd5, 4'b1111};
        tbl[6] = '{3'd6, 4'b1010};
        tbl[7] = '{3'd7, 4'b1001};

        rst_n     = 1'b0;
        i_data    = 3'd0;
        prev_code = 4'b0000;

        for (int i = 0; i < 5; i++) begin
            tick();
            chk("reset code", 32'(o_crc_code), 32'd0);
            chk("reset done", 32'(o_crc_done), 32'd0);
        end
        rst_n = 1'b1;

        for (int f = 0; f < 3; f++)
            run_frame(3'd1, 3'd1, 4'b0011, "single");

        for (int i = 0; i < 8; i++)
            run_frame(tbl[i].data, tbl[i].data, tbl[i].code, $sformatf("sweep%0d", i));

        run_frame(3'd5, 3'd2, 4'b1111, "midchange");
        run_frame(3'd2, 3'd2, 4'b0110, "after_mid");

        i_data = 3'd7;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("async clear code", 32'(o_crc_code), 32'd0);
        chk("async clear done", 32'(o_crc_done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("aborted frame done", 32'(o_crc_done), 32'd0);
            chk("aborted frame code", 32'(o_crc_code), 32'd0);
        end
        rst_n     = 1'b1;
        prev_code = 4'b0000;
        run_frame(3'd7, 3'd7, 4'b1001, "post_reset");
        run_frame(3'd4, 3'd4, 4'b1100, "post_reset2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
